// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period down-counter: counts CLKS_PER_BAUD-1 .. 0 while enabled, ticks
// on 0 and reloads itself. An explicit reload restarts a full bit period.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BAUD = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic reload,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BAUD);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BAUD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: reload wins, otherwise count down and wrap at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = CntMax;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? CntMax : cnt_q - CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BAUD = 868
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_empty,
    input  logic [7:0] i_data,
    output logic       o_rd,
    output logic       o_tx,
    output logic       o_busy
);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic                      rd_q;
    logic                      capture;
    logic                      tick;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (i_reset),
        .en     (state_q != StIdle),
        .reload (capture),
        .tick   (tick)
    );

    // Next-state and next line level; a capture can start a frame from IDLE or
    // straight out of the last stop cycle, giving zero-gap back-to-back frames.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        capture   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = LINE_IDLE;
                if (!i_empty) capture = 1'b1;
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
                        tx_d      = par_q;
`else
                        state_d   = StStop;
                        tx_d      = LINE_STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
`ifdef UART_TX_PARITY_EN
                if (tick) begin
                    state_d = StStop;
                    tx_d    = LINE_STOP;
                end
`else
                state_d = StIdle;
                tx_d    = LINE_IDLE;
`endif
            end
            StStop: begin
                if (tick) begin
                    if (!i_empty) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tx_d    = LINE_IDLE;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = LINE_IDLE;
            end
        endcase

        if (capture) begin
            state_d   = StStart;
            shift_d   = i_data;
            bit_idx_d = '0;
            tx_d      = LINE_START;
`ifdef UART_TX_PARITY_EN
            par_d     = ^i_data;
`endif
        end
    end

    // Frame state, line and pop strobe registers.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= LINE_IDLE;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            rd_q      <= capture;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the captured byte, held for the whole frame.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign o_tx   = tx_q;
    assign o_rd   = rd_q;
    assign o_busy = (state_q != StIdle);

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter that drains a FIFO through its read port. It pops bytes from the transmit FIFO (first-word-fall-through: data valid whenever not empty, pop with a one-cycle read strobe). Each byte is sent as an 8N1 frame, LSB first, on `o_tx`. It sits between the TX FIFO and the board's serial pin, and is the read-side counterpart of the FIFO writer in the UART path.

## Interface
- `CLKS_PER_BAUD`, 868, clock cycles per bit period (100 MHz / 115200); legal range ≥ 2.
- `clk`  input  1  single clock; all logic on rising edge.
- `i_reset`  input  1  reset, asynchronous, active-high.
- `i_empty`  input  1  FIFO empty flag; `i_data` valid when low.
- `i_data`  input  8  FIFO head byte (combinational from FIFO).
- `o_rd`  output  1  FIFO pop strobe, registered, one-cycle pulse.
- `o_tx`  output  1  serial line, idle high, registered.
- `o_busy`  output  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE → START when `i_empty`=0.
  - START → DATA after one bit period.
  - DATA → PARITY/STOP after 8 bit periods.
  - PARITY → STOP after one bit period.
  - At the last cycle of STOP:
    - → START if `i_empty`=0 (capture and pop as in IDLE);
    - else → IDLE.
- Capture edge:
  - `i_data` latched into 8-bit shift register.
  - State → START; `o_tx` ← 0; baud counter ← `CLKS_PER_BAUD`-1.
  - `o_rd` ← 1 for exactly the next cycle, so the FIFO pops on the following edge.
  - No second capture can occur before the pop, since the state is no longer IDLE or end-of-STOP.
- Baud counter:
  - Width $clog2(`CLKS_PER_BAUD`); counts down to 0; tick at 0, then reload.
  - On tick in DATA, shift right and drive the LSB next; 3-bit bit index wraps 7 → exit.
- `o_tx` per state:
  - START: 0.
  - DATA: `shift[0]`.
  - PARITY: even parity of the captured byte.
  - STOP: 1.
  - IDLE: 1.
- Reset (async, any time, including mid-frame):
  - State IDLE; `o_tx`=1; `o_rd`=0; `o_busy`=0; counter and bit index 0.
  - A partially sent byte is lost and not re-fetched.
- `i_empty` is ignored outside IDLE and the last STOP cycle.

## Timing
- Reset values: `o_tx`=1, `o_rd`=0, `o_busy`=0.
- Latency: `o_tx` falls on the same edge that samples `i_empty`=0 in IDLE.
- Frame length is 10×`CLKS_PER_BAUD` cycles (11× with parity), each bit exactly `CLKS_PER_BAUD` cycles.
- Back-to-back frames have zero idle gap; `o_rd` pulses are spaced exactly one frame apart.
- `o_busy` rises with the start bit and falls the cycle after the last STOP cycle when the FIFO is empty.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP, carrying an even parity bit (XOR of the 8 data bits).
  - Frame is 11 bit periods.
- Not defined:
  - PARITY state and parity logic absent.
  - 8N1 frame of 10 bit periods.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS`=8;
  - idle/start/stop line level constants.
- Sub-module `uart_baud_cnt`:
  - parameterised down-counter with reload input and tick output;
  - reusable by the receiver.

## Test plan
Bench uses `CLKS_PER_BAUD`=4.
- Reset asserted with FIFO non-empty → `o_tx`=1, `o_rd`=0, `o_busy`=0 throughout reset.
- FIFO holds 0xA5 → `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles); single `o_rd` pulse one cycle after the start-bit edge; then `o_busy`=0.
- FIFO holds 0x00 then 0xFF → 80 contiguous cycles, no idle high between the first stop bit and the second start bit; two `o_rd` pulses 40 cycles apart.
- `UART_TX_PARITY_EN` defined, byte 0x07 → parity bit 1 after bit 7, frame 44 cycles; byte 0x03 → parity bit 0.
- `i_reset` asserted mid-DATA (bit 3) → `o_tx`=1 asynchronously; `o_rd` stays 0; after release with next byte 0x3C waiting → fresh full frame of 0x3C.
- FIFO empty for 100 cycles → `o_tx`=1, `o_rd` never asserted, `o_busy`=0.
